// File: rtl/edge_box_detector_pkg.sv
// Shared types and defaults for edge_box_detector and the digit recogniser.
// EDGE_MARGIN_EN adds the margin default and saturating helpers.
package edge_box_detector_pkg;

    localparam int H_RES_DEFAULT   = 640;
    localparam int V_RES_DEFAULT   = 480;
    localparam int MIN_RUN_DEFAULT = 3;
    localparam int PIX_W           = 10;

    localparam logic [9:0] PIX_BLACK = 10'h000;
    localparam logic [9:0] PIX_WHITE = 10'h3FF;

    // Packed edge words: low field is top/left, high field is bottom/right.
    localparam int EDGE_LO_LSB = 0;
    localparam int EDGE_HI_LSB = 10;

    typedef enum logic [1:0] {
        WAIT_SOF,
        SCAN,
        PUBLISH
    } state_t;

`ifdef EDGE_MARGIN_EN
    localparam int MARGIN_DEFAULT = 2;

    function automatic logic [9:0] sat_sub(input logic [9:0] v, input logic [9:0] m);
        return (v > m) ? v - m : 10'd0;
    endfunction

    function automatic logic [9:0] sat_add(input logic [9:0] v, input logic [9:0] m,
                                           input logic [9:0] lim);
        logic [10:0] s;
        s = {1'b0, v} + {1'b0, m};
        return (s > {1'b0, lim}) ? lim : s[9:0];
    endfunction
`endif

endpackage

// File: rtl/edge_box_detector_run.sv
// edge_run_filter: per-line black run counter; flags pixels belonging to a run
// of at least MIN_RUN and reports where that run started.
module edge_run_filter
    import edge_box_detector_pkg::*;
#(
    parameter int MIN_RUN = MIN_RUN_DEFAULT
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [9:0] col,
    input  logic       black,
    output logic       counted,
    output logic [9:0] run_start
);

    localparam logic [3:0] RUN_MAX  = 4'(MIN_RUN);
    localparam logic [9:0] RUN_BACK = 10'(MIN_RUN - 1);

    logic [3:0] run;
    logic [3:0] run_base;
    logic [3:0] run_next;

    // Column 0 starts a fresh line, so a run can never carry across lines.
    always_comb begin
        run_base = (col == '0) ? 4'd0 : run;
        run_next = 4'd0;
        if (black) begin
            run_next = (run_base == RUN_MAX) ? RUN_MAX : run_base + 4'd1;
        end
    end

    assign counted   = black && (run_next == RUN_MAX);
    assign run_start = col - RUN_BACK;

    always_ff @(posedge clk) begin
        if (!rst) begin
            run <= 4'd0;
        end else if (en) begin
            run <= run_next;
        end
    end

endmodule

// File: rtl/edge_box_detector.sv
// edge_box_detector: bounding box of run-filtered black pixels per frame,
// published at end of frame. Define EDGE_MARGIN_EN to grow the box by MARGIN.
module edge_box_detector
    import edge_box_detector_pkg::*;
#(
    parameter int H_RES   = H_RES_DEFAULT,
    parameter int V_RES   = V_RES_DEFAULT,
    parameter int MIN_RUN = MIN_RUN_DEFAULT
`ifdef EDGE_MARGIN_EN
    ,
    parameter int MARGIN  = MARGIN_DEFAULT
`endif
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [9:0]  iRow,
    input  logic [9:0]  iCol,
    input  logic [9:0]  iBWData,
    output logic [19:0] oEdge_Row,
    output logic [19:0] oEdge_Col,
    output logic        oFound,
    output logic        oValid
);

    localparam logic [9:0] LAST_ROW = 10'(V_RES - 1);
    localparam logic [9:0] LAST_COL = 10'(H_RES - 1);

    state_t      state;
    logic [9:0]  top, bottom, left, right;
    logic        any_hit;
    logic [9:0]  top_next, bottom_next, left_next, right_next;
    logic        hit_next;
    logic        black, counted, sof, eof;
    logic [9:0]  run_start;
    logic [19:0] pub_row, pub_col;

    assign black = (iBWData == PIX_BLACK);
    assign sof   = (iRow == '0) && (iCol == '0);
    assign eof   = (iRow == LAST_ROW) && (iCol == LAST_COL);

    edge_run_filter #(.MIN_RUN(MIN_RUN)) u_run (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .col       (iCol),
        .black     (black),
        .counted   (counted),
        .run_start (run_start)
    );

    // A frame start (first or resync) folds its pixel into empty accumulators.
    always_comb begin
        top_next    = top;
        bottom_next = bottom;
        left_next   = left;
        right_next  = right;
        hit_next    = any_hit;
        if (state != SCAN || sof) begin
            top_next    = 10'h3FF;
            left_next   = 10'h3FF;
            bottom_next = 10'd0;
            right_next  = 10'd0;
            hit_next    = 1'b0;
        end
        if (counted) begin
            if (iRow < top_next)      top_next    = iRow;
            if (iRow > bottom_next)   bottom_next = iRow;
            if (iCol > right_next)    right_next  = iCol;
            if (run_start < left_next) left_next  = run_start;
            hit_next = 1'b1;
        end
    end

    always_comb begin
        pub_row = '0;
        pub_col = '0;
        if (any_hit) begin
`ifdef EDGE_MARGIN_EN
            pub_row[EDGE_LO_LSB +: PIX_W] = sat_sub(top, 10'(MARGIN));
            pub_row[EDGE_HI_LSB +: PIX_W] = sat_add(bottom, 10'(MARGIN), LAST_ROW);
            pub_col[EDGE_LO_LSB +: PIX_W] = sat_sub(left, 10'(MARGIN));
            pub_col[EDGE_HI_LSB +: PIX_W] = sat_add(right, 10'(MARGIN), LAST_COL);
`else
            pub_row[EDGE_LO_LSB +: PIX_W] = top;
            pub_row[EDGE_HI_LSB +: PIX_W] = bottom;
            pub_col[EDGE_LO_LSB +: PIX_W] = left;
            pub_col[EDGE_HI_LSB +: PIX_W] = right;
`endif
        end
    end

    // Frame sequencing; outputs only ever change in the PUBLISH cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= WAIT_SOF;
            top       <= 10'h3FF;
            left      <= 10'h3FF;
            bottom    <= 10'd0;
            right     <= 10'd0;
            any_hit   <= 1'b0;
            oEdge_Row <= '0;
            oEdge_Col <= '0;
            oFound    <= 1'b0;
            oValid    <= 1'b0;
        end else begin
            oValid <= 1'b0;
            case (state)
                WAIT_SOF: begin
                    if (en && sof) begin
                        top     <= top_next;
                        bottom  <= bottom_next;
                        left    <= left_next;
                        right   <= right_next;
                        any_hit <= hit_next;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (en) begin
                        top     <= top_next;
                        bottom  <= bottom_next;
                        left    <= left_next;
                        right   <= right_next;
                        any_hit <= hit_next;
                        if (eof && !sof) begin
                            state <= PUBLISH;
                        end
                    end
                end
                PUBLISH: begin
                    oEdge_Row <= pub_row;
                    oEdge_Col <= pub_col;
                    oFound    <= any_hit;
                    oValid    <= 1'b1;
                    state     <= WAIT_SOF;
                end
                default: state <= WAIT_SOF;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_box_detector.sv
// Self-checking bench for edge_box_detector: sparse raster frames built from
// black line segments, checked every cycle against a bounding-box model.
module tb_edge_box_detector;
    import edge_box_detector_pkg::*;

    localparam int H      = 640;
    localparam int V      = 480;
    localparam int MINRUN = 3;
`ifdef EDGE_MARGIN_EN
    localparam int MARG   = 2;
`endif

    typedef struct { int row; int c0; int c1; } seg_t;
    typedef struct { int cyc; logic [19:0] erow; logic [19:0] ecol; logic efound; } pub_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [9:0]  iRow = '0;
    logic [9:0]  iCol = '0;
    logic [9:0]  iBWData = PIX_WHITE;
    logic [19:0] oEdge_Row, oEdge_Col;
    logic        oFound, oValid;

    seg_t  segs[$];
    pub_t  pubq[$];
    int    cyc = 0;
    int    checks = 0;
    int    fails = 0;
    int    pulses = 0;
    int    last_r = 0;
    int    last_c = 0;
    bit    checking = 1'b0;
    bit    rand_en = 1'b0;
    logic [19:0] hold_row = '0;
    logic [19:0] hold_col = '0;
    logic        hold_found = 1'b0;

    edge_box_detector #(.H_RES(H), .V_RES(V), .MIN_RUN(MINRUN)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .iRow      (iRow),
        .iCol      (iCol),
        .iBWData   (iBWData),
        .oEdge_Row (oEdge_Row),
        .oEdge_Col (oEdge_Col),
        .oFound    (oFound),
        .oValid    (oValid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Box model: plain min/max over every segment long enough to survive the filter.
    function automatic pub_t model();
        pub_t p;
        int t, b, l, r;
        bit hit;
        t = 1023; b = 0; l = 1023; r = 0; hit = 1'b0;
        foreach (segs[i]) begin
            if (segs[i].c1 - segs[i].c0 + 1 >= MINRUN) begin
                hit = 1'b1;
                if (segs[i].row < t) t = segs[i].row;
                if (segs[i].row > b) b = segs[i].row;
                if (segs[i].c0 < l) l = segs[i].c0;
                if (segs[i].c1 > r) r = segs[i].c1;
            end
        end
        p.cyc = 0;
        p.erow = '0;
        p.ecol = '0;
        p.efound = hit;
        if (hit) begin
`ifdef EDGE_MARGIN_EN
            t = (t > MARG) ? t - MARG : 0;
            l = (l > MARG) ? l - MARG : 0;
            b = (b + MARG > V - 1) ? V - 1 : b + MARG;
            r = (r + MARG > H - 1) ? H - 1 : r + MARG;
`endif
            p.erow = {10'(b), 10'(t)};
            p.ecol = {10'(r), 10'(l)};
        end
        return p;
    endfunction

    // Every cycle: oValid must pulse exactly when a publish is due, outputs must hold otherwise.
    always @(negedge clk) begin
        bit expv;
        if (checking) begin
            expv = (pubq.size() > 0) && (pubq[0].cyc == cyc);
            if (expv) begin
                hold_row   = pubq[0].erow;
                hold_col   = pubq[0].ecol;
                hold_found = pubq[0].efound;
                void'(pubq.pop_front());
            end
            if (oValid === 1'b1) pulses++;
            checkOutput("valid", 32'(oValid), 32'(expv));
            checkOutput("edge_row", 32'(oEdge_Row), 32'(hold_row));
            checkOutput("edge_col", 32'(oEdge_Col), 32'(hold_col));
            checkOutput("found", 32'(oFound), 32'(hold_found));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            en = 1'b1; iRow = 10'd0; iCol = 10'd1; iBWData = PIX_WHITE;
            @(posedge clk); #1;
        end
    endtask

    task automatic pix(input int r, input int c, input bit blk);
        if (rand_en) begin
            while ($urandom_range(1, 0) == 1) begin
                en = 1'b0;
                iRow = 10'($urandom_range(V - 1, 0));
                iCol = 10'($urandom_range(H - 1, 0));
                iBWData = 10'($urandom_range(1, 0) == 1 ? 0 : 1023);
                @(posedge clk); #1;
            end
        end
        en = 1'b1;
        iRow = 10'(r);
        iCol = 10'(c);
        iBWData = blk ? PIX_BLACK : (((r + c) % 5 == 0) ? 10'h001 : PIX_WHITE);
        @(posedge clk); #1;
        last_r = r;
        last_c = c;
    endtask

    task automatic applyStimulus(input int upto_row, input bit complete);
        pub_t p;
        int lo, hi;
        pix(0, 0, 1'b0);
        foreach (segs[i]) begin
            if (segs[i].row <= upto_row) begin
                lo = (segs[i].c0 > 0) ? segs[i].c0 - 1 : 0;
                hi = (segs[i].c1 < H - 1) ? segs[i].c1 + 1 : H - 1;
                if (lo > 0) pix(segs[i].row, 0, 1'b0);
                for (int c = lo; c <= hi; c++)
                    pix(segs[i].row, c, (c >= segs[i].c0) && (c <= segs[i].c1));
            end
        end
        if (complete) begin
            if (!(last_r == V - 1 && last_c == H - 1)) pix(V - 1, H - 1, 1'b0);
            p = model();
            p.cyc = cyc + 1;
            pubq.push_back(p);
        end
    endtask

    task automatic addRect();
        segs.push_back('{100, 200, 260});
        segs.push_back('{101, 200, 260});
        segs.push_back('{200, 200, 260});
        segs.push_back('{299, 200, 260});
        segs.push_back('{300, 200, 260});
    endtask

    task automatic addDecoy();
        segs.push_back('{50, 10, 600});
        segs.push_back('{150, 5, 630});
    endtask

    task automatic checkRect(input string tag);
`ifdef EDGE_MARGIN_EN
        checkOutput({tag, "_row"}, 32'(oEdge_Row), 32'({10'd302, 10'd98}));
        checkOutput({tag, "_col"}, 32'(oEdge_Col), 32'({10'd262, 10'd198}));
`else
        checkOutput({tag, "_row"}, 32'(oEdge_Row), 32'({10'd300, 10'd100}));
        checkOutput({tag, "_col"}, 32'(oEdge_Col), 32'({10'd260, 10'd200}));
`endif
        checkOutput({tag, "_found"}, 32'(oFound), 32'd1);
    endtask

    initial begin
        int p0;
        idle(3);
        checking = 1'b1;
        idle(2);
        checkOutput("reset_row", 32'(oEdge_Row), 32'd0);
        checkOutput("reset_found", 32'(oFound), 32'd0);
        rst = 1'b1;
        idle(3);

        // All-white frame
        segs.delete();
        p0 = pulses;
        applyStimulus(V - 1, 1'b1);
        idle(3);
        checkOutput("white_pulses", 32'(pulses - p0), 32'd1);
        checkOutput("white_found", 32'(oFound), 32'd0);
        checkOutput("white_row", 32'(oEdge_Row), 32'd0);
        checkOutput("white_col", 32'(oEdge_Col), 32'd0);

        // Rectangle
        segs.delete(); addRect();
        applyStimulus(V - 1, 1'b1);
        idle(3);
        checkRect("rect");

        // Runs of exactly MIN_RUN, one starting at column 0, and a rejected pair
        segs.delete();
        segs.push_back('{10, 5, 7});
        segs.push_back('{12, 0, 2});
        segs.push_back('{20, 100, 101});
        applyStimulus(V - 1, 1'b1);
        idle(3);
`ifdef EDGE_MARGIN_EN
        checkOutput("minrun_row", 32'(oEdge_Row), 32'({10'd14, 10'd8}));
        checkOutput("minrun_col", 32'(oEdge_Col), 32'({10'd9, 10'd0}));
`else
        checkOutput("minrun_row", 32'(oEdge_Row), 32'({10'd12, 10'd10}));
        checkOutput("minrun_col", 32'(oEdge_Col), 32'({10'd7, 10'd0}));
`endif

        // Noise runs plus rectangle; a line-end pair must not join the next line's col 0
        segs.delete();
        segs.push_back('{40, 10, 11});
        addRect();
        segs.push_back('{350, 400, 401});
        segs.push_back('{400, 638, 639});
        segs.push_back('{401, 0, 0});
        applyStimulus(V - 1, 1'b1);
        idle(3);
        checkRect("noise");

        // Random pixel qualifier
        segs.delete(); addRect();
        rand_en = 1'b1;
        p0 = pulses;
        applyStimulus(V - 1, 1'b1);
        rand_en = 1'b0;
        idle(3);
        checkOutput("rand_en_pulses", 32'(pulses - p0), 32'd1);
        checkRect("rand_en");

        // Reset in the middle of a frame
        segs.delete(); addDecoy(); addRect();
        p0 = pulses;
        applyStimulus(200, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        pubq.delete();
        hold_row = '0; hold_col = '0; hold_found = 1'b0;
        rst = 1'b1;
        idle(1);
        checkOutput("midreset_row", 32'(oEdge_Row), 32'd0);
        checkOutput("midreset_found", 32'(oFound), 32'd0);
        segs.delete(); addRect();
        applyStimulus(V - 1, 1'b1);
        idle(3);
        checkOutput("midreset_pulses", 32'(pulses - p0), 32'd1);
        checkRect("midreset");

        // Resync on (0,0) in the middle of a frame
        segs.delete(); addDecoy(); addRect();
        p0 = pulses;
        applyStimulus(200, 1'b0);
        segs.delete(); addRect();
        applyStimulus(V - 1, 1'b1);
        idle(3);
        checkOutput("resync_pulses", 32'(pulses - p0), 32'd1);
        checkRect("resync");

        // Box touching every frame edge
        segs.delete();
        segs.push_back('{1, 0, H - 1});
        segs.push_back('{240, 0, H - 1});
        segs.push_back('{V - 1, 0, H - 1});
        applyStimulus(V - 1, 1'b1);
        idle(3);
`ifdef EDGE_MARGIN_EN
        checkOutput("full_row", 32'(oEdge_Row), 32'({10'd479, 10'd0}));
`else
        checkOutput("full_row", 32'(oEdge_Row), 32'({10'd479, 10'd1}));
`endif
        checkOutput("full_col", 32'(oEdge_Col), 32'({10'd639, 10'd0}));

        idle(2);
        checkOutput("pending_publishes", 32'(pubq.size()), 32'd0);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #5000000;
        fails++;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
